coproc_link_master: RTL

Host-side initiator for the UART coprocessor link. It takes a parallel request word, serialises it as 8N1 UART bytes on the link TX line, then pulses the data-input strobe pin. It collects the coprocessor's UART response bytes into a parallel word and also samples the coprocessor's output-valid pin. It sits on the driving board and wires pin-for-pin to the coprocessor board's interconnect[3:0].

---
 rtl/coproc_link_master.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/coproc_link_master.sv
// coproc_link_master: serialises a request word as 8N1 UART, strobes the coprocessor,
// then collects its UART response bytes with a timeout and result-flag capture.
module coproc_link_master #(
    parameter int CLKS_PER_BIT   = 897,
    parameter int REQ_BYTES      = 1,
    parameter int RESP_BYTES     = 1,
    parameter int STROBE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [8*REQ_BYTES-1:0]  req_data,
    input  logic                    req_valid,
    output logic                    req_ready,
    output logic [8*RESP_BYTES-1:0] resp_data,
    output logic                    resp_valid,
    output logic                    resp_timeout,
    output logic                    resp_flag,
    output logic                    link_tx,
    input  logic                    link_rx,
    output logic                    link_din_valid,
    input  logic                    link_dout_valid
);
    localparam int M1 = (CLKS_PER_BIT > STROBE_CYCLES) ? CLKS_PER_BIT : STROBE_CYCLES;
    localparam int CW = $clog2(((M1 > TIMEOUT_CYCLES) ? M1 : TIMEOUT_CYCLES) + 1);
    localparam int IW = $clog2(((REQ_BYTES > RESP_BYTES) ? REQ_BYTES : RESP_BYTES) + 1);
    localparam int BW = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {IDLE, TX_BYTE, STROBE, RECV, DONE} state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

    state_t                  state, state_n;
    logic [CW-1:0]           cnt, cnt_n;
    logic [3:0]              tx_bit, tx_bit_n;
    logic [IW-1:0]           idx, idx_n;
    logic [8*REQ_BYTES-1:0]  req_sh, req_sh_n;
    logic                    flag, flag_n;
    logic [8*RESP_BYTES-1:0] data_n;
    logic                    valid_n, timeout_n, rflag_n, tx_n, din_n;

    logic                    rx_s1, rx_s2, rx_s3, dv_s1, dv_s2;
    rstate_t                 rstate, rstate_n;
    logic [BW-1:0]           rcnt, rcnt_n;
    logic [2:0]              rbit, rbit_n;
    logic [7:0]              rsh, rsh_n;
    logic                    rx_done;

    always_comb begin
        rstate_n = rstate;
        rcnt_n   = rcnt + 1'b1;
        rbit_n   = rbit;
        rsh_n    = rsh;
        rx_done  = 1'b0;
        case (rstate)
            R_IDLE: begin
                rcnt_n = '0;
                if (rx_s3 && !rx_s2) rstate_n = R_START;
            end
            R_START: if (rcnt == BW'(CLKS_PER_BIT/2 - 1)) begin
                rcnt_n   = '0;
                rbit_n   = '0;
                rstate_n = rx_s2 ? R_IDLE : R_DATA;
            end
            R_DATA: if (rcnt == BW'(CLKS_PER_BIT - 1)) begin
                rcnt_n = '0;
                rsh_n  = {rx_s2, rsh[7:1]};
                rbit_n = rbit + 3'd1;
                if (rbit == 3'd7) rstate_n = R_STOP;
            end
            R_STOP: if (rcnt == BW'(CLKS_PER_BIT - 1)) begin
                rx_done  = rx_s2;
                rstate_n = R_IDLE;
            end
            default: rstate_n = R_IDLE;
        endcase
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        tx_bit_n  = tx_bit;
        idx_n     = idx;
        req_sh_n  = req_sh;
        flag_n    = flag;
        data_n    = resp_data;
        valid_n   = 1'b0;
        timeout_n = resp_timeout;
        rflag_n   = resp_flag;
        tx_n      = link_tx;
        din_n     = link_din_valid;
        case (state)
            IDLE: if (req_valid && req_ready) begin
                state_n  = TX_BYTE;
                req_sh_n = req_data;
                data_n   = '0;
                idx_n    = '0;
                cnt_n    = '0;
                tx_bit_n = '0;
                flag_n   = 1'b0;
                tx_n     = 1'b0;
            end
            TX_BYTE: begin
                // tx_bit 10 is the single idle-high cycle between frames
                if (tx_bit == 4'd10) begin
                    tx_bit_n = '0;
                    cnt_n    = '0;
                    tx_n     = 1'b0;
                end else if (cnt == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_n    = '0;
                    tx_bit_n = tx_bit + 4'd1;
                    tx_n     = (tx_bit < 4'd8) ? req_sh[tx_bit[2:0]] : 1'b1;
                    if (tx_bit == 4'd9) begin
                        req_sh_n = req_sh >> 8;
                        idx_n    = idx + 1'b1;
                        if (idx == IW'(REQ_BYTES - 1)) begin
                            state_n = STROBE;
                            din_n   = 1'b1;
                        end
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STROBE: if (cnt == CW'(STROBE_CYCLES - 1)) begin
                state_n = RECV;
                cnt_n   = '0;
                idx_n   = '0;
                din_n   = 1'b0;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            RECV: begin
                flag_n = flag | dv_s2;
                // a good byte wins over a same-cycle timeout expiry
                if (rx_done) begin
                    data_n[8*int'(idx) +: 8] = rsh;
                    idx_n = idx + 1'b1;
                    cnt_n = '0;
                    if (idx == IW'(RESP_BYTES - 1)) begin
                        state_n   = DONE;
                        valid_n   = 1'b1;
                        timeout_n = 1'b0;
                        rflag_n   = flag_n;
                    end
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_n   = DONE;
                    valid_n   = 1'b1;
                    timeout_n = 1'b1;
                    rflag_n   = flag_n;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            tx_bit         <= '0;
            idx            <= '0;
            req_sh         <= '0;
            flag           <= 1'b0;
            req_ready      <= 1'b0;
            resp_data      <= '0;
            resp_valid     <= 1'b0;
            resp_timeout   <= 1'b0;
            resp_flag      <= 1'b0;
            link_tx        <= 1'b1;
            link_din_valid <= 1'b0;
            rx_s1          <= 1'b1;
            rx_s2          <= 1'b1;
            rx_s3          <= 1'b1;
            dv_s1          <= 1'b0;
            dv_s2          <= 1'b0;
            rstate         <= R_IDLE;
            rcnt           <= '0;
            rbit           <= '0;
            rsh            <= '0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            tx_bit         <= tx_bit_n;
            idx            <= idx_n;
            req_sh         <= req_sh_n;
            flag           <= flag_n;
            req_ready      <= (state_n == IDLE);
            resp_data      <= data_n;
            resp_valid     <= valid_n;
            resp_timeout   <= timeout_n;
            resp_flag      <= rflag_n;
            link_tx        <= tx_n;
            link_din_valid <= din_n;
            rx_s1          <= link_rx;
            rx_s2          <= rx_s1;
            rx_s3          <= rx_s2;
            dv_s1          <= link_dout_valid;
            dv_s2          <= dv_s1;
            rstate         <= rstate_n;
            rcnt           <= rcnt_n;
            rbit           <= rbit_n;
            rsh            <= rsh_n;
        end
    end
endmodule
